// File: rtl/sa_output_deskew_if.sv
`default_nettype none
// ============================================================================
// Module      : sa_output_deskew_if
// Description : Column-stream inputs and row-stream outputs of the systolic
//               array output collector. Optional row_sum under ROW_SUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface sa_output_deskew_if #(
    parameter int N_COLS     = 4,
    parameter int P_BITWIDTH = 24,
    parameter int FIFO_DEPTH = 4
);
    logic [N_COLS-1:0]            col_valid;
    logic [N_COLS*P_BITWIDTH-1:0] col_data;
    logic                         row_valid;
    logic                         row_ready;
    logic [N_COLS*P_BITWIDTH-1:0] row_data;
    logic [$clog2(FIFO_DEPTH):0]  fifo_count;
    logic                         overflow;
    logic                         skew_err;
`ifdef ROW_SUM_EN
    logic [P_BITWIDTH+$clog2(N_COLS)-1:0] row_sum;

    modport master (
        input  col_valid, col_data, row_ready,
        output row_valid, row_data, fifo_count, overflow, skew_err, row_sum
    );
    modport slave (
        output col_valid, col_data, row_ready,
        input  row_valid, row_data, fifo_count, overflow, skew_err, row_sum
    );
`else
    modport master (
        input  col_valid, col_data, row_ready,
        output row_valid, row_data, fifo_count, overflow, skew_err
    );
    modport slave (
        output col_valid, col_data, row_ready,
        input  row_valid, row_data, fifo_count, overflow, skew_err
    );
`endif
endinterface
`default_nettype wire

// File: rtl/sa_output_deskew.sv
`default_nettype none
// ============================================================================
// Module      : sa_output_deskew
// Description : Re-aligns skewed per-column results from the MAC array bottom
//               row into row vectors and buffers them in a show-ahead FIFO.
//               Macro ROW_SUM_EN adds a stored per-row unsigned column sum.
// Revision    : 1.0 - initial release
// ============================================================================
module sa_output_deskew #(
    parameter int N_COLS     = 4,
    parameter int P_BITWIDTH = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    sa_output_deskew_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int RW = N_COLS * P_BITWIDTH;
    localparam int SW = P_BITWIDTH + $clog2(N_COLS);

    logic [N_COLS-1:0] w_al_v;
    logic [RW-1:0]     w_al_d;

    // Column j is delayed N_COLS-1-j cycles so every column lines up with the last one.
    for (genvar j = 0; j < N_COLS; j++) begin : g_col
        localparam int D = N_COLS - 1 - j;
        if (D == 0) begin : g_pass
            assign w_al_v[j]                         = bus.col_valid[j];
            assign w_al_d[j*P_BITWIDTH +: P_BITWIDTH] = bus.col_data[j*P_BITWIDTH +: P_BITWIDTH];
        end else begin : g_dly
            logic [D-1:0]          dly_v_q, dly_v_d;
            logic [P_BITWIDTH-1:0] dly_d_q [D];
            logic [P_BITWIDTH-1:0] dly_d_d [D];

            always_comb begin
                dly_v_d[0] = bus.col_valid[j];
                dly_d_d[0] = bus.col_data[j*P_BITWIDTH +: P_BITWIDTH];
                for (int k = 1; k < D; k++) begin
                    dly_v_d[k] = dly_v_q[k-1];
                    dly_d_d[k] = dly_d_q[k-1];
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    dly_v_q <= '0;
                    for (int k = 0; k < D; k++) dly_d_q[k] <= '0;
                end else begin
                    dly_v_q <= dly_v_d;
                    dly_d_q <= dly_d_d;
                end
            end

            assign w_al_v[j]                         = dly_v_q[D-1];
            assign w_al_d[j*P_BITWIDTH +: P_BITWIDTH] = dly_d_q[D-1];
        end
    end

    logic [RW-1:0] mem_q [FIFO_DEPTH];
    logic [RW-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [RW-1:0] row_data_q, row_data_d;
    logic          overflow_q, overflow_d, skew_err_q, skew_err_d;
    logic          w_push_req, w_mixed, w_full, w_pop, w_wr_en, w_bypass;

    assign w_push_req = &w_al_v;
    assign w_mixed    = (|w_al_v) && !w_push_req;
    assign w_full     = (count_q == (AW+1)'(FIFO_DEPTH));
    assign w_pop      = (count_q != '0) && bus.row_ready;
    // A full FIFO still accepts a row when the head leaves on the same edge.
    assign w_wr_en    = w_push_req && (!w_full || w_pop);

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q + (w_wr_en ? AW'(1) : AW'(0));
        rd_ptr_d   = rd_ptr_q + (w_pop ? AW'(1) : AW'(0));
        count_d    = count_q + (w_wr_en ? (AW+1)'(1) : (AW+1)'(0))
                             - (w_pop   ? (AW+1)'(1) : (AW+1)'(0));
        overflow_d = overflow_q | (w_push_req && w_full && !w_pop);
        skew_err_d = skew_err_q | w_mixed;
        w_bypass   = w_wr_en && (wr_ptr_q == rd_ptr_d);
        if (w_wr_en) mem_d[wr_ptr_q] = w_al_d;
        // Output register holds the next head; it keeps its value once the FIFO empties.
        row_data_d = row_data_q;
        if (count_d != '0) row_data_d = w_bypass ? w_al_d : mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            row_data_q <= '0;
            overflow_q <= 1'b0;
            skew_err_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            row_data_q <= row_data_d;
            overflow_q <= overflow_d;
            skew_err_q <= skew_err_d;
        end
    end

    assign bus.row_valid  = (count_q != '0);
    assign bus.row_data   = row_data_q;
    assign bus.fifo_count = count_q;
    assign bus.overflow   = overflow_q;
    assign bus.skew_err   = skew_err_q;

`ifdef ROW_SUM_EN
    logic [SW-1:0] sum_mem_q [FIFO_DEPTH];
    logic [SW-1:0] sum_mem_d [FIFO_DEPTH];
    logic [SW-1:0] row_sum_q, row_sum_d, w_sum;

    always_comb begin
        w_sum = '0;
        for (int j = 0; j < N_COLS; j++) w_sum = w_sum + SW'(w_al_d[j*P_BITWIDTH +: P_BITWIDTH]);
        sum_mem_d = sum_mem_q;
        if (w_wr_en) sum_mem_d[wr_ptr_q] = w_sum;
        row_sum_d = row_sum_q;
        if (count_d != '0) row_sum_d = w_bypass ? w_sum : sum_mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) sum_mem_q[i] <= '0;
            row_sum_q <= '0;
        end else begin
            sum_mem_q <= sum_mem_d;
            row_sum_q <= row_sum_d;
        end
    end

    assign bus.row_sum = row_sum_q;
`else
    localparam int UNUSED_SW = SW;
`endif
endmodule
`default_nettype wire

// File: tb/tb_sa_output_deskew.sv
`default_nettype none
// ============================================================================
// Module      : tb_sa_output_deskew
// Description : Scoreboard bench: rows are expected from the column-skew rule
//               applied to the recorded input history; a monitor checks them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sa_output_deskew;
    localparam int N      = 4;
    localparam int P      = 24;
    localparam int DEPTH  = 4;
    localparam int RW     = N * P;
    localparam int SW     = P + $clog2(N);
    localparam int MAXCYC = 20000;

    typedef struct {
        logic [RW-1:0] data;
        logic [SW-1:0] sum;
    } row_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sa_output_deskew_if #(.N_COLS(N), .P_BITWIDTH(P), .FIFO_DEPTH(DEPTH)) bus ();
    sa_output_deskew #(.N_COLS(N), .P_BITWIDTH(P), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   tests = 0;
    int   fails = 0;
    row_t sb_q[$];
    int   m_cnt = 0;
    bit   m_ovf = 1'b0;
    bit   m_skew = 1'b0;
    int   cyc = 0;
    logic [N-1:0]  in_v [MAXCYC];
    logic [RW-1:0] in_d [MAXCYC];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference: in cycle t the aligned column j is whatever column j carried in t-(N-1-j).
    initial forever begin
        @(posedge clk);
        if (!rst) begin
            sb_q.delete();
            m_cnt  = 0;
            m_ovf  = 1'b0;
            m_skew = 1'b0;
            for (int k = 0; k < N; k++) if (cyc - k >= 0) in_v[cyc-k] = '0;
        end else begin
            logic [N-1:0]  av;
            logic [RW-1:0] ad;
            bit            pop;
            row_t          r;
            in_v[cyc] = bus.col_valid;
            in_d[cyc] = bus.col_data;
            av = '0;
            ad = '0;
            for (int j = 0; j < N; j++) begin
                int src;
                src = cyc - (N - 1 - j);
                if (src >= 0) begin
                    av[j]       = in_v[src][j];
                    ad[j*P +: P] = in_d[src][j*P +: P];
                end
            end
            pop = (m_cnt != 0) && bus.row_ready;
            if (pop) m_cnt--;
            if (av == {N{1'b1}}) begin
                if (m_cnt < DEPTH) begin
                    r.data = ad;
                    r.sum  = '0;
                    for (int j = 0; j < N; j++) r.sum = r.sum + SW'(ad[j*P +: P]);
                    sb_q.push_back(r);
                    m_cnt++;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (av != '0) begin
                m_skew = 1'b1;
            end
        end
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("rst_row_valid", 128'(bus.row_valid), 128'(0));
            chk("rst_fifo_count", 128'(bus.fifo_count), 128'(0));
            chk("rst_overflow", 128'(bus.overflow), 128'(0));
            chk("rst_skew_err", 128'(bus.skew_err), 128'(0));
            chk("rst_row_data", 128'(bus.row_data), 128'(0));
        end else begin
            chk("fifo_count", 128'(bus.fifo_count), 128'(m_cnt));
            chk("row_valid", 128'(bus.row_valid), 128'(m_cnt != 0));
            chk("overflow", 128'(bus.overflow), 128'(m_ovf));
            chk("skew_err", 128'(bus.skew_err), 128'(m_skew));
            if (bus.row_valid && bus.row_ready) begin
                if (sb_q.size() == 0) begin
                    chk("pop_unexpected", 128'(1), 128'(0));
                end else begin
                    row_t e;
                    e = sb_q.pop_front();
                    chk("row_data", 128'(bus.row_data), 128'(e.data));
`ifdef ROW_SUM_EN
                    chk("row_sum", 128'(bus.row_sum), 128'(e.sum));
`endif
                end
            end
        end
    end

    // rmode: 0 ready low, 1 ready high, 2 random, 3 high only in the last cycle
    task automatic play(input int nrows, input int rmode, input bit rnd, input int dbase,
                        input int skip_row, input int skip_col, input int gap);
        int            rs [64];
        logic [P-1:0]  dd [64][N];
        logic [N-1:0]  v;
        logic [RW-1:0] d;
        int            last;
        for (int k = 0; k < nrows; k++) begin
            rs[k] = (k == 0) ? 0 : rs[k-1] + ((gap == 0) ? int'($urandom_range(1, 3)) : gap);
            for (int j = 0; j < N; j++) dd[k][j] = rnd ? P'($urandom()) : P'(dbase + k*10 + j);
        end
        last = rs[nrows-1] + N - 1;
        for (int t = 0; t <= last; t++) begin
            @(posedge clk);
            #1;
            v = '0;
            d = RW'({$urandom(), $urandom(), $urandom()});
            for (int k = 0; k < nrows; k++)
                for (int j = 0; j < N; j++)
                    if (rs[k] + j == t && !(k == skip_row && j == skip_col)) begin
                        v[j]        = 1'b1;
                        d[j*P +: P] = dd[k][j];
                    end
            bus.col_valid = v;
            bus.col_data  = d;
            case (rmode)
                0:       bus.row_ready = 1'b0;
                1:       bus.row_ready = 1'b1;
                2:       bus.row_ready = 1'($urandom_range(0, 1));
                default: bus.row_ready = (t == last);
            endcase
        end
    endtask

    task automatic idle(input int n, input int rmode);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus.col_valid = '0;
            bus.col_data  = RW'({$urandom(), $urandom(), $urandom()});
            bus.row_ready = (rmode == 0) ? 1'b0 : (rmode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.col_valid = '0;
        bus.row_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int n, rm, sr;
        bus.col_valid = {N{1'b1}};
        bus.col_data  = RW'({$urandom(), $urandom(), $urandom()});
        bus.row_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst           = 1'b1;
        bus.col_valid = '0;
        idle(5, 1);

        play(1, 1, 1'b0, 100, -1, 0, 1);
        idle(6, 1);

        play(6, 0, 1'b0, 0, -1, 0, 1);
        idle(3, 0);
        idle(10, 1);

        do_reset();
        play(4, 0, 1'b0, 200, -1, 0, 1);
        idle(3, 0);
        play(1, 3, 1'b0, 300, -1, 0, 1);
        idle(10, 1);

        do_reset();
        play(1, 1, 1'b0, 400, 0, 2, 1);
        idle(3, 1);
        play(1, 1, 1'b0, 500, -1, 0, 1);
        idle(6, 1);

        do_reset();
        @(posedge clk); #1; bus.col_valid = 4'b0001; bus.col_data = RW'(7);
        @(posedge clk); #1; bus.col_valid = 4'b0010; bus.col_data = RW'(8) << P;
        @(posedge clk); #1; rst = 1'b0; bus.col_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        idle(8, 1);

        do_reset();
        for (int it = 0; it < 40; it++) begin
            n  = int'($urandom_range(1, 8));
            rm = int'($urandom_range(0, 2));
            sr = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            play(n, rm, 1'b1, 0, sr, int'($urandom_range(0, N - 1)), int'($urandom_range(0, 2)));
            idle(int'($urandom_range(0, 6)), int'($urandom_range(1, 2)));
            if ($urandom_range(0, 7) == 0) do_reset();
        end

        idle(20, 1);
        @(negedge clk);
        chk("scoreboard_drained", 128'(sb_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/sa_output_deskew.md
Name: sa_output_deskew

Overview:
- Collects partial-sum results leaving the bottom row of the systolic MAC array. Each column's result arrives one cycle later than the column to its left.
- Re-aligns the per-column streams into one row vector and buffers complete rows in a small FIFO.
- Presents rows downstream through a valid/ready handshake.
- The array cannot stall, so buffer overflow and skew faults are flagged and never back-pressured.

Parameters:
N_COLS, 4, number of array columns feeding the collector
P_BITWIDTH, 24, width of one partial-sum result
FIFO_DEPTH, 4, number of complete rows buffered (power of two, >=2)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
col_valid  input  N_COLS  per-column result strobe from bottom-row PE; bit j = column j
col_data  input  N_COLS*P_BITWIDTH  per-column P_out; column j at bits [j*P_BITWIDTH +: P_BITWIDTH]
row_valid  output  1  head row available
row_ready  input  1  downstream accepts head row
row_data  output  N_COLS*P_BITWIDTH  head row, same column packing as col_data
fifo_count  output  $clog2(FIFO_DEPTH)+1  rows currently buffered
overflow  output  1  sticky: a complete row was dropped because FIFO full
skew_err  output  1  sticky: aligned valids were neither all-0 nor all-1

Behaviour:
- Reset (rst low, asynchronous): all delay-line stages, FIFO pointers and FIFO contents cleared.
  - row_valid=0, row_data=0, fifo_count=0, overflow=0, skew_err=0.
  - Applies immediately, including mid-row; partially aligned rows are discarded.
- Deskew: column j (valid+data) passes through N_COLS-1-j register stages. Column N_COLS-1 has zero stages.
  - Delay outputs form the aligned vector combinationally.
- Row completion, evaluated each cycle on the aligned vector:
  - all aligned valids 1 -> push request with aligned data;
  - all 0 -> nothing;
  - mixed -> no push, skew_err set next edge; the partial row is dropped.
- Push/pop at a clock edge:
  - Pop occurs when row_valid && row_ready.
  - Push with FIFO not full: row written, count+1.
  - Push with FIFO full and no pop: row dropped, overflow set, contents unchanged.
  - Push with FIFO full and pop in the same cycle: push accepted, count unchanged, no overflow.
  - Pop only: count-1. Pop with empty FIFO cannot occur because row_valid=0.
- Outputs:
  - row_valid = (fifo_count != 0).
  - row_data shows the head entry (show-ahead). When row_valid=0 it holds its last value (0 after reset).
  - Read/write pointers wrap modulo FIFO_DEPTH.
- Latency: column 0 valid in cycle c with column j in c+j gives row_valid high in cycle c+N_COLS (FIFO initially empty).
  - Throughput: one row per cycle.
- row_valid/row_data stable while row_valid && !row_ready.
- overflow and skew_err clear only on reset.
- No arithmetic; data passes unmodified except in the optional feature.

Optional Feature:
- Macro ROW_SUM_EN.
- Defined:
  - Extra output port row_sum, width P_BITWIDTH+$clog2(N_COLS), carrying the unsigned sum of all N_COLS columns of the head row.
  - Sum computed at push time, zero-extended, no overflow possible.
  - Stored in the FIFO alongside the row; 0 after reset.
- Undefined: port and storage absent; all other behaviour identical.

Test Plan:
- Reset: hold rst=0 with col_valid=4'hF -> row_valid=0, fifo_count=0, overflow=0, skew_err=0. Release: no spurious row.
- Single row: col j valid in cycle 10+j with data 100+j, row_ready=1.
  - row_valid=1 only in cycle 14.
  - row_data columns 0..3 = 100,101,102,103.
  - With ROW_SUM_EN, row_sum=406.
- Overflow: 6 back-to-back skewed rows (data k*10+j), row_ready=0.
  - fifo_count saturates at 4; overflow=1 after row 5 is dropped.
  - Then row_ready=1 drains rows 0..3 in order; fifo_count returns to 0.
- Full push+pop: FIFO full, row_ready=1 while a new row completes -> fifo_count stays 4, overflow stays 0, new row appears after the 3 older rows.
- Skew fault: skewed row with column 2 valid suppressed -> nothing pushed, skew_err=1, fifo_count unchanged. The next clean row is still accepted.
- Reset mid-row: assert rst after columns 0,1 sent -> after release, fifo_count=0, no row emitted, stickies 0.
